// File: rtl/aes_block_packer_pkg.sv
// Shared AES constants, packer state encoding, control bundle and the tail byte-enable helper.
package aes_package;

  localparam int unsigned AES_BLOCK_BYTES     = 16;
  localparam int unsigned AES_WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_OUTPUT,
    PK_DONE
  } aes_packer_state_t;

  typedef struct packed {
    logic        clear;
    logic        enable;
    logic        start;
    logic [31:0] data_size;
  } ctrl_packer_t;

  // A zero tail count means the final word is complete, so every byte stays enabled.
  function automatic logic [3:0] aes_tail_mask(input logic [1:0] tail_bytes);
    logic [3:0] mask;
    unique case (tail_bytes)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Packs 32-bit stream words into 128-bit AES blocks and zero-pads the final block of each job.
module aes_block_packer
  import aes_package::*;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic [31:0]        data_size_i,
  input  logic [WORD_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic               block_valid_o,
  input  logic               block_ready_i,
  output logic               block_last_o,
  output logic               busy_o,
  output logic               done_o
);

  ctrl_packer_t       ctrl;
  aes_packer_state_t  state, next_state;
  logic [BLOCK_W-1:0] buffer;
  logic [1:0]         wcnt;
  logic [30:0]        words_left;
  logic [1:0]         tail_bytes;
  logic               accept;
  logic               handshake;
  logic [32:0]        size_round;
  logic [3:0]         byte_en;
  logic [WORD_W-1:0]  masked_word;

  assign ctrl = '{clear: clear_i, enable: enable_i, start: start_i, data_size: data_size_i};

  // Rounded up in 33 bits so a size near 2^32 cannot wrap before the divide by four.
  assign size_round = {1'b0, ctrl.data_size} + 33'd3;

  always_comb begin
    byte_en     = (words_left == 31'd1) ? aes_tail_mask(tail_bytes) : 4'hF;
    masked_word = in_data_i;
    for (int k = 0; k < 4; k++) begin
      if (!byte_en[k]) masked_word[8*k +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= PK_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      PK_IDLE: begin
        if (ctrl.start) next_state = (ctrl.data_size == 32'd0) ? PK_DONE : PK_FILL;
      end
      PK_FILL: begin
        if (in_valid_i) begin
          accept = 1'b1;
          if (wcnt == 2'(AES_WORDS_PER_BLOCK - 1) || words_left == 31'd1) next_state = PK_OUTPUT;
        end
      end
      PK_OUTPUT: begin
        if (block_ready_i) begin
          handshake  = 1'b1;
          next_state = (words_left == 31'd0) ? PK_DONE : PK_FILL;
        end
      end
      PK_DONE: next_state = PK_IDLE;
      default: next_state = PK_IDLE;
    endcase
    // A low enable freezes everything, but a clear still aborts the job.
    if (!ctrl.enable) begin
      next_state = state;
      accept     = 1'b0;
      handshake  = 1'b0;
    end
    if (ctrl.clear) begin
      next_state = PK_IDLE;
      accept     = 1'b0;
      handshake  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buffer     <= '0;
      wcnt       <= '0;
      words_left <= '0;
      tail_bytes <= '0;
    end else if (ctrl.clear) begin
      buffer     <= '0;
      wcnt       <= '0;
      words_left <= '0;
      tail_bytes <= '0;
    end else if (ctrl.enable) begin
      if (state == PK_IDLE && ctrl.start) begin
        words_left <= size_round[32:2];
        tail_bytes <= ctrl.data_size[1:0];
      end
      if (accept) begin
        for (int i = 0; i < AES_WORDS_PER_BLOCK; i++) begin
          if (wcnt == 2'(i)) buffer[BLOCK_W-1-WORD_W*i -: WORD_W] <= masked_word;
        end
        wcnt       <= wcnt + 2'd1;
        words_left <= words_left - 31'd1;
      end
      if (handshake) begin
        buffer <= '0;
        wcnt   <= '0;
      end
    end
  end

  assign in_ready_o    = ctrl.enable && (state == PK_FILL);
  assign block_valid_o = (state == PK_OUTPUT);
  assign block_last_o  = (state == PK_OUTPUT) && (words_left == 31'd0);
  assign block_o       = buffer;
  assign busy_o        = (state != PK_IDLE);
  assign done_o        = ctrl.enable && (state == PK_DONE);

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed jobs plus randomized jobs against a byte-stream model.
module tb_aes_block_packer;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic         start;
  logic [31:0]  data_size;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] block;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic         busy;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  wordq[$];
  logic [127:0] firstBlockSeen;
  logic [127:0] lastBlockSeen;

  aes_block_packer #(.WORD_W(32), .BLOCK_W(128)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .enable_i     (enable),
    .start_i      (start),
    .data_size_i  (data_size),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .block_o      (block),
    .block_valid_o(block_valid),
    .block_ready_i(block_ready),
    .block_last_o (block_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [31:0] sz, input logic vld,
                               input logic [31:0] dat, input logic rdy);
    start       = st;
    data_size   = sz;
    in_valid    = vld;
    in_data     = dat;
    block_ready = rdy;
  endtask

  // Model: the job is a little-endian byte stream; bytes past the size are zero, 16 bytes per block,
  // the first stream word lands in the top 32 bits of the block.
  function automatic logic [127:0] expBlock(input int b, input int size);
    logic [127:0] r;
    logic [31:0]  w;
    int           idx;
    r = '0;
    for (int m = 0; m < 16; m++) begin
      idx = 16*b + m;
      if (idx < size) begin
        w = wordq[idx/4];
        r[96 - 32*(m/4) + 8*(m%4) +: 8] = w[8*(m%4) +: 8];
      end
    end
    return r;
  endfunction

  task automatic runJob(input string tag, input int size, input int validPolicy, input int readyPolicy,
                        input int freezeAfter, input int fillMode);
    int           nwords, nblocks, wIdx, bIdx, cyc, lastHs, doneCyc, holdCnt;
    logic         vld, rdy, prevStall, froze, sawValid, sawReady;
    logic [127:0] prevBlock, snap;
    logic [31:0]  w;
    nwords  = (size + 3) / 4;
    nblocks = (size + 15) / 16;
    wordq.delete();
    for (int j = 0; j < nwords; j++) begin
      if (fillMode == 1)      w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      else if (fillMode == 2) w = 32'hFFFF_FFFF;
      else                    w = $urandom;
      wordq.push_back(w);
    end
    wIdx = 0; bIdx = 0; lastHs = -1; doneCyc = -1; holdCnt = 0;
    prevStall = 1'b0; froze = 1'b0; prevBlock = '0;
    @(negedge clk);
    applyStimulus(1'b1, 32'(size), 1'b0, 32'h0, 1'b0);
    for (cyc = 1; cyc <= 3000 && doneCyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput({tag, "_first_ready"}, 128'(in_ready), 128'(1'b1));
      if (prevStall) begin
        checkOutput({tag, "_hold_valid"}, 128'(block_valid), 128'(1'b1));
        checkOutput({tag, "_hold_block"}, block, prevBlock);
      end
      if (block_valid) checkOutput({tag, "_no_ready_in_output"}, 128'(in_ready), 128'(1'b0));
      if (done) begin
        doneCyc = cyc;
        checkOutput({tag, "_done_latency"}, 128'(cyc), 128'(lastHs + 1));
      end
      if (doneCyc < 0 && freezeAfter >= 0 && !froze && wIdx == freezeAfter && in_ready) begin
        froze  = 1'b1;
        snap   = block;
        enable = 1'b0;
        applyStimulus(1'b0, 32'(size), 1'b1, wordq[wIdx], 1'b1);
        repeat (5) begin
          @(negedge clk);
          cyc++;
          checkOutput({tag, "_freeze_ready"}, 128'(in_ready), 128'(1'b0));
          checkOutput({tag, "_freeze_valid"}, 128'(block_valid), 128'(1'b0));
          checkOutput({tag, "_freeze_block"}, block, snap);
        end
        enable = 1'b1;
        #1;
      end
      sawValid = block_valid;
      sawReady = in_ready;
      vld = (doneCyc < 0) && (wIdx < nwords) && (validPolicy == 0 || $urandom_range(0, 2) != 0);
      if (readyPolicy == 0)      rdy = 1'b1;
      else if (readyPolicy == 1) rdy = ($urandom_range(0, 2) == 0);
      else                       rdy = sawValid && (holdCnt >= 10);
      if (sawValid) holdCnt++;
      applyStimulus(1'b0, 32'(size), vld, (wIdx < nwords) ? wordq[wIdx] : 32'h0, rdy);
      if (vld && sawReady) wIdx++;
      if (sawValid && rdy) begin
        checkOutput({tag, "_block"}, block, expBlock(bIdx, size));
        checkOutput({tag, "_last"}, 128'(block_last), 128'(bIdx == nblocks - 1));
        if (bIdx == 0) firstBlockSeen = block;
        lastBlockSeen = block;
        bIdx++;
        lastHs  = cyc;
        holdCnt = 0;
      end
      prevStall = sawValid && !rdy;
      prevBlock = block;
    end
    checkOutput({tag, "_finished"}, 128'(doneCyc >= 0), 128'(1'b1));
    checkOutput({tag, "_words"}, 128'(wIdx), 128'(nwords));
    checkOutput({tag, "_blocks"}, 128'(bIdx), 128'(nblocks));
    if (validPolicy == 0 && readyPolicy == 0 && freezeAfter < 0 && size % 16 == 0)
      checkOutput({tag, "_throughput"}, 128'(doneCyc), 128'(5*nblocks + 1));
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 128'(done), 128'(1'b0));
    checkOutput({tag, "_idle_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    int sizes[8];
    int n;
    sizes = '{1, 4, 15, 17, 33, 47, 64, 0};
    rst_n  = 1'b0;
    clear  = 1'b0;
    enable = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("reset_valid", 128'(block_valid), 128'(1'b0));
    checkOutput("reset_ready", 128'(in_ready), 128'(1'b0));
    checkOutput("reset_done", 128'(done), 128'(1'b0));
    checkOutput("reset_block", block, 128'h0);

    $display("[TB] one full block");
    runJob("full", 16, 0, 0, -1, 1);
    checkOutput("full_const", firstBlockSeen, 128'h03020100_07060504_0B0A0908_0F0E0D0C);

    $display("[TB] partial tail");
    runJob("tail", 21, 0, 0, -1, 2);
    checkOutput("tail_first", firstBlockSeen, {128{1'b1}});
    checkOutput("tail_last", lastBlockSeen, 128'hFFFFFFFF_000000FF_00000000_00000000);

    $display("[TB] zero length");
    @(negedge clk);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    checkOutput("zero_done", 128'(done), 128'(1'b1));
    checkOutput("zero_valid", 128'(block_valid), 128'(1'b0));
    checkOutput("zero_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    checkOutput("zero_done_end", 128'(done), 128'(1'b0));
    checkOutput("zero_ready_end", 128'(in_ready), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("[TB] backpressure and throughput");
    runJob("bp", 32, 0, 2, -1, 0);
    runJob("thru", 48, 0, 0, -1, 0);

    $display("[TB] enable freeze");
    runJob("freeze", 16, 0, 0, 2, 1);
    checkOutput("freeze_const", firstBlockSeen, 128'h03020100_07060504_0B0A0908_0F0E0D0C);

    $display("[TB] clear in output");
    @(negedge clk);
    applyStimulus(1'b1, 32'd32, 1'b0, 32'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!block_valid && n < 20) begin
      applyStimulus(1'b0, 32'd32, 1'b1, $urandom, 1'b0);
      @(negedge clk);
      n++;
    end
    checkOutput("clear_reach_output", 128'(block_valid), 128'(1'b1));
    clear = 1'b1;
    applyStimulus(1'b0, 32'd32, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("clear_valid", 128'(block_valid), 128'(1'b0));
    checkOutput("clear_block", block, 128'h0);
    checkOutput("clear_busy", 128'(busy), 128'(1'b0));
    checkOutput("clear_last", 128'(block_last), 128'(1'b0));
    checkOutput("clear_done", 128'(done), 128'(1'b0));
    @(negedge clk);
    checkOutput("clear_no_done", 128'(done), 128'(1'b0));
    runJob("after_clear", 4, 1, 1, -1, 0);

    $display("[TB] async reset mid fill");
    @(negedge clk);
    applyStimulus(1'b1, 32'd32, 1'b0, 32'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'd32, 1'b1, 32'hA5A5_5A5A, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'(1'b0));
    checkOutput("rst_ready", 128'(in_ready), 128'(1'b0));
    checkOutput("rst_block", block, 128'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", 128'(block_valid), 128'(1'b0));

    $display("[TB] randomized jobs");
    for (int j = 0; j < 7; j++) runJob("edge", sizes[j], 1, 1, -1, 0);
    for (int j = 0; j < 6; j++) runJob("rand", $urandom_range(1, 80), 1, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
